// File: rtl/insn_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : insn_mem_arbiter_pkg
//  Description : Shared types and constants for the instruction-memory
//                arbiter: FSM state encoding and memory access sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
package insn_mem_arbiter_pkg;

    // Arbiter phases: loader owns memory, pipeline drain, fetch owns memory
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Memory access size encoding shared by loader and fetch
    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    // Drain counter is wide enough for the largest legal drain length (15)
    localparam int c_DRAIN_CNT_W = 4;

endpackage : insn_mem_arbiter_pkg
`default_nettype wire

// File: rtl/insn_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : insn_mem_arbiter
//  Description : Arbitrates the instruction memory port between the image
//                loader (writes) and instruction fetch (reads). Fetch is
//                stalled while loading and for a short drain period after
//                the loader reports completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module insn_mem_arbiter
    import insn_mem_arbiter_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    input  logic [1:0]       ld_size,
    input  logic             ld_done,
    output logic             ld_gnt,
    input  logic [31:0]      fetch_pc,
    input  logic [1:0]       fetch_size,
    output logic             stall_out,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    output logic             mem_write,
    output logic [1:0]       mem_size,
    output logic [CNT_W-1:0] ld_count,
    output logic             busy
);

    // Value loaded on DRAIN entry so that DRAIN lasts exactly DRAIN_CYCLES
    localparam logic [c_DRAIN_CNT_W-1:0] c_DRAIN_INIT = c_DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]         c_CNT_MAX    = '1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_DRAIN_CNT_W-1:0] r_drain_cnt;
    logic [c_DRAIN_CNT_W-1:0] w_drain_cnt_nxt;
    logic [CNT_W-1:0]         r_ld_count;
    logic [CNT_W-1:0]         w_ld_count_nxt;
    logic                     w_gnt;
    logic                     w_in_load;

    assign w_in_load = (r_state == ST_LOAD);

    // Loader grant: same-cycle pass-through in LOAD, suppressed during reset
    always_comb begin
        w_gnt = 1'b0;
        if (rst_n && w_in_load) begin
            w_gnt = ld_req;
        end
    end

    // State, drain counter and loader-write counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_drain_cnt <= '0;
            r_ld_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_ld_count  <= w_ld_count_nxt;
        end
    end

    // Next-state, drain countdown and saturating write count
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_ld_count_nxt  = r_ld_count;

        // A write granted in the ld_done cycle still counts
        if (w_gnt && (r_ld_count != c_CNT_MAX)) begin
            w_ld_count_nxt = r_ld_count + 1'b1;
        end

        case (r_state)
            ST_LOAD: begin
                if (ld_done) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                // A new load request aborts the drain; it is granted from LOAD
                if (ld_req) begin
                    w_state_nxt     = ST_LOAD;
                    w_drain_cnt_nxt = '0;
                end else if (r_drain_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                // A fresh load session restarts the write count
                if (ld_req) begin
                    w_state_nxt    = ST_LOAD;
                    w_ld_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_LOAD;
                w_drain_cnt_nxt = '0;
            end
        endcase
    end

    // Memory port mux, selected by registered state
    always_comb begin
        mem_addr  = fetch_pc;
        mem_size  = fetch_size;
        mem_data  = ld_data;
        mem_write = w_gnt;
        if (w_in_load) begin
            mem_addr = ld_addr;
            mem_size = ld_size;
        end
    end

    assign ld_gnt    = w_gnt;
    assign stall_out = (r_state != ST_RUN);
    assign busy      = w_in_load;
    assign ld_count  = r_ld_count;

endmodule : insn_mem_arbiter
`default_nettype wire

// File: tb/tb_insn_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_insn_mem_arbiter
//  Description : Directed table-driven bench for insn_mem_arbiter, with a
//                second narrow-counter instance for ld_count saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_mem_arbiter;

    localparam logic [31:0] c_PC = 32'h8002_0000;

    logic        clk;
    logic        rst_n;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [1:0]  ld_size;
    logic        ld_done;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_size;

    logic        ld_gnt,    ld_gnt2;
    logic        stall_out, stall_out2;
    logic [31:0] mem_addr,  mem_addr2;
    logic [31:0] mem_data,  mem_data2;
    logic        mem_write, mem_write2;
    logic [1:0]  mem_size,  mem_size2;
    logic [15:0] ld_count;
    logic [1:0]  ld_count2;
    logic        busy,      busy2;

    int n_vec  = 0;
    int n_fail = 0;

    insn_mem_arbiter #(.DRAIN_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_size(ld_size), .ld_done(ld_done),
        .ld_gnt(ld_gnt), .fetch_pc(fetch_pc), .fetch_size(fetch_size),
        .stall_out(stall_out), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_write(mem_write), .mem_size(mem_size), .ld_count(ld_count),
        .busy(busy)
    );

    insn_mem_arbiter #(.DRAIN_CYCLES(2), .CNT_W(2)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_size(ld_size), .ld_done(ld_done),
        .ld_gnt(ld_gnt2), .fetch_pc(fetch_pc), .fetch_size(fetch_size),
        .stall_out(stall_out2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .mem_write(mem_write2), .mem_size(mem_size2), .ld_count(ld_count2),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        done;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] pc;
        logic        e_gnt;
        logic        e_stall;
        logic        e_busy;
        logic [31:0] e_addr;
        logic [1:0]  e_size;
        int          e_cnt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic req, input logic done,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input logic [31:0] pc,
                                input logic e_gnt, input logic e_stall,
                                input logic e_busy, input logic [31:0] e_addr,
                                input logic [1:0] e_size, input int e_cnt);
        vec_t v;
        v.req = req;     v.done = done;     v.addr = addr;   v.data = data;
        v.size = size;   v.pc = pc;         v.e_gnt = e_gnt; v.e_stall = e_stall;
        v.e_busy = e_busy; v.e_addr = e_addr; v.e_size = e_size; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // fetch_size is half-word throughout so it differs from loader sizes
        fetch_size = 2'd1;
        //             req done addr          data        sz  pc           gnt st bz e_addr        esz cnt
        tbl[0]  = mk(1, 0, 32'h8002_0000, 32'hA, 2, c_PC,        1, 1, 1, 32'h8002_0000, 2, 0);
        tbl[1]  = mk(1, 0, 32'h8002_0004, 32'hB, 2, c_PC,        1, 1, 1, 32'h8002_0004, 2, 1);
        tbl[2]  = mk(1, 0, 32'h8002_0008, 32'hC, 2, c_PC,        1, 1, 1, 32'h8002_0008, 2, 2);
        tbl[3]  = mk(0, 0, 32'h0,         32'h0, 0, c_PC,        0, 1, 1, 32'h0,         0, 3);
        tbl[4]  = mk(0, 1, 32'h0,         32'h0, 2, c_PC,        0, 1, 1, 32'h0,         2, 3);
        tbl[5]  = mk(0, 0, 32'h0,         32'h0, 2, c_PC,        0, 1, 0, c_PC,          1, 3);
        tbl[6]  = mk(0, 0, 32'h0,         32'h0, 2, c_PC,        0, 1, 0, c_PC,          1, 3);
        tbl[7]  = mk(0, 1, 32'h0,         32'h0, 2, c_PC,        0, 0, 0, c_PC,          1, 3);
        tbl[8]  = mk(0, 0, 32'h0,         32'h0, 2, c_PC + 'h10, 0, 0, 0, c_PC + 'h10,   1, 3);
        tbl[9]  = mk(1, 0, 32'h8002_1000, 32'hD, 2, c_PC + 'h20, 0, 0, 0, c_PC + 'h20,   1, 3);
        tbl[10] = mk(1, 0, 32'h8002_1000, 32'hD, 2, c_PC + 'h20, 1, 1, 1, 32'h8002_1000, 2, 0);
        tbl[11] = mk(1, 1, 32'h8002_1004, 32'hE, 2, c_PC + 'h20, 1, 1, 1, 32'h8002_1004, 2, 1);
        tbl[12] = mk(1, 0, 32'h8002_1008, 32'hF, 2, c_PC + 'h20, 0, 1, 0, c_PC + 'h20,   1, 2);
        tbl[13] = mk(1, 0, 32'h8002_1008, 32'hF, 2, c_PC + 'h20, 1, 1, 1, 32'h8002_1008, 2, 2);
        tbl[14] = mk(0, 1, 32'h0,         32'h0, 2, c_PC,        0, 1, 1, 32'h0,         2, 3);
        tbl[15] = mk(0, 0, 32'h0,         32'h0, 2, c_PC,        0, 1, 0, c_PC,          1, 3);

        // Reset state, with a request pending that must not be granted
        rst_n = 1'b0; ld_req = 1'b1; ld_done = 1'b0;
        ld_addr = 32'h8002_0000; ld_data = 32'h1; ld_size = 2'd2; fetch_pc = c_PC;
        #3;
        chk("reset stall", 32'(stall_out), 32'd1);
        chk("reset busy",  32'(busy),      32'd1);
        chk("reset gnt",   32'(ld_gnt),    32'd0);
        chk("reset write", 32'(mem_write), 32'd0);
        chk("reset count", 32'(ld_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1; ld_req = 1'b0;

        // Main table: load three words, drain, run, reload, abort drain
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            ld_req = tbl[i].req;   ld_done = tbl[i].done; ld_addr = tbl[i].addr;
            ld_data = tbl[i].data; ld_size = tbl[i].size; fetch_pc = tbl[i].pc;
            @(negedge clk);
            chk($sformatf("row%0d gnt", i),   32'(ld_gnt),    32'(tbl[i].e_gnt));
            chk($sformatf("row%0d write", i), 32'(mem_write), 32'(tbl[i].e_gnt));
            chk($sformatf("row%0d stall", i), 32'(stall_out), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d busy", i),  32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("row%0d addr", i),  mem_addr,       tbl[i].e_addr);
            chk($sformatf("row%0d size", i),  32'(mem_size),  32'(tbl[i].e_size));
            chk($sformatf("row%0d data", i),  mem_data,       tbl[i].data);
            chk($sformatf("row%0d count", i), 32'(ld_count),  32'(tbl[i].e_cnt));
            chk($sformatf("row%0d count2", i), 32'(ld_count2), 32'(tbl[i].e_cnt));
        end

        // Reset asserted mid-drain takes effect without a clock edge
        ld_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("middrain rst stall", 32'(stall_out), 32'd1);
        chk("middrain rst busy",  32'(busy),      32'd1);
        chk("middrain rst count", 32'(ld_count),  32'd0);
        chk("middrain rst gnt",   32'(ld_gnt),    32'd0);
        chk("middrain rst write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        chk("rst held write", 32'(mem_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ld_req = 1'b0;

        // Five back-to-back writes: wide counter reaches 5, narrow saturates at 3
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ld_req = 1'b1; ld_done = 1'b0;
            ld_addr = 32'h8003_0000 + 32'(i * 4); ld_data = 32'(i);
            @(negedge clk);
            chk($sformatf("sat%0d gnt", i),    32'(ld_gnt2),   32'd1);
            chk($sformatf("sat%0d stall", i),  32'(stall_out), 32'd1);
            chk($sformatf("sat%0d count", i),  32'(ld_count),  32'(i));
            chk($sformatf("sat%0d count2", i), 32'(ld_count2), (i > 3) ? 32'd3 : 32'(i));
        end
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(negedge clk);
        chk("sat final count",  32'(ld_count),  32'd5);
        chk("sat final count2", 32'(ld_count2), 32'd3);
        chk("sat final gnt",    32'(ld_gnt),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_insn_mem_arbiter
`default_nettype wire

// File: doc/insn_mem_arbiter.md
INSN_MEM_ARBITER -- requirements
Module: insn_mem_arbiter

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles held in DRAIN after load completes; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of ld_count.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ld_req  input  1  loader write request; held until granted.
REQ-006 ld_addr  input  32  loader write address.
REQ-007 ld_data  input  32  loader write data.
REQ-008 ld_size  input  2  loader access size.
REQ-009 ld_done  input  1  single-cycle pulse: loader has finished its image.
REQ-010 ld_gnt  output  1  loader write accepted this cycle.
REQ-011 fetch_pc  input  32  fetch read address.
REQ-012 fetch_size  input  2  fetch access size.
REQ-013 stall_out  output  1  holds fetch PC while high.
REQ-014 mem_addr  output  32  instruction memory address.
REQ-015 mem_data  output  32  instruction memory write data.
REQ-016 mem_write  output  1  instruction memory write enable.
REQ-017 mem_size  output  2  instruction memory access size.
REQ-018 ld_count  output  CNT_W  loader writes accepted since the last load session began.
REQ-019 busy  output  1  high while in LOAD.

Function
REQ-020 FSM states: LOAD, DRAIN, RUN; exactly one active.
REQ-021 LOAD: ld_gnt = ld_req, combinationally, same cycle; mem_addr/mem_data/mem_size = ld_addr/ld_data/ld_size; mem_write = ld_gnt.
REQ-022 DRAIN and RUN: ld_gnt = 0; mem_write = 0; mem_addr = fetch_pc; mem_size = fetch_size; mem_data = ld_data.
REQ-023 stall_out = 1 in LOAD and DRAIN, 0 in RUN; driven from registered state only.
REQ-024 LOAD -> DRAIN on ld_done. If ld_req is high in the same cycle, that write is still granted and completed.
REQ-025 Entering DRAIN loads the drain counter with DRAIN_CYCLES-1.
REQ-026 DRAIN -> RUN when the counter is 0; otherwise the counter decrements.
REQ-027 DRAIN -> LOAD on ld_req, which aborts the drain. No grant is given that cycle; the write is granted on the next cycle in LOAD.
REQ-028 RUN -> LOAD on ld_req.
  - ld_count is cleared to 0 on this transition.
  - The request is granted one cycle later; stall_out rises one cycle after the request.
REQ-029 ld_done outside LOAD is ignored.
REQ-030 ld_count increments by 1 on each ld_gnt and saturates at all-ones without wrapping.
REQ-031 busy = (state == LOAD).

Reset
REQ-032 While rst_n = 0, asynchronously:
  - state = LOAD, drain counter = 0, ld_count = 0
  - stall_out = 1, busy = 1
  - ld_gnt = 0, mem_write = 0
REQ-033 Release of rst_n is synchronised by the integrator; the first edge after release evaluates from LOAD.
REQ-034 Reset asserted mid-write or mid-drain discards the session. No write is issued while rst_n = 0.

Structure
REQ-035 The shared package holds the state encoding (LOAD=2'd0, DRAIN=2'd1, RUN=2'd2) and the access-size constants (byte, half, word).
REQ-036 Single module, no sub-modules. The datapath muxing is inline, selected by registered state.

Verification
REQ-037 Reset, then ld_req high for 3 cycles with addr 0x80020000/4/8 and data 0xA..C -> three mem_write pulses at those addresses, ld_count = 3, stall_out = 1 throughout.
REQ-038 ld_done with DRAIN_CYCLES = 2 -> DRAIN for exactly 2 cycles, stall_out falls on the 3rd edge, mem_addr tracks fetch_pc = 0x80020000.
REQ-039 ld_req and ld_done in the same LOAD cycle -> write performed, ld_count increments, next state DRAIN.
REQ-040 ld_req in the 1st DRAIN cycle -> returns to LOAD, grant one cycle later, stall_out never drops.
REQ-041 In RUN, ld_req -> stall_out high the next cycle, ld_count = 0, then a grant; preload ld_count near all-ones (CNT_W = 2, 5 writes) -> saturates at 3.
REQ-042 Assert rst_n low during DRAIN -> stall_out = 1, ld_count = 0 immediately, with no clock edge required.
